// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
// Bus between the MEM stage and the data-memory controller.
//   Integer path : req_i_en, req_i_we, req_i_addr, req_i_wdata -> rdata_i, rvalid_i
//   FP path      : req_f_en, req_f_we, req_f_addr, req_f_wdata -> rdata_f, rvalid_f
//   Shared       : mem_stall (freezes EX/MEM), misalign (completion of a
//                  misaligned access)
// The master modport is the pipeline side and the slave modport is the
// controller side.
// -----------------------------------------------------------------------------
interface dmem_ctrl_if;
    logic        req_i_en;
    logic        req_i_we;
    logic [31:0] req_i_addr;
    logic [31:0] req_i_wdata;
    logic        req_f_en;
    logic        req_f_we;
    logic [31:0] req_f_addr;
    logic [31:0] req_f_wdata;
    logic [31:0] rdata_i;
    logic        rvalid_i;
    logic [31:0] rdata_f;
    logic        rvalid_f;
    logic        mem_stall;
    logic        misalign;

    modport master (
        output req_i_en, req_i_we, req_i_addr, req_i_wdata,
        output req_f_en, req_f_we, req_f_addr, req_f_wdata,
        input  rdata_i, rvalid_i, rdata_f, rvalid_f, mem_stall, misalign
    );

    modport slave (
        input  req_i_en, req_i_we, req_i_addr, req_i_wdata,
        input  req_f_en, req_f_we, req_f_addr, req_f_wdata,
        output rdata_i, rvalid_i, rdata_f, rvalid_f, mem_stall, misalign
    );
endinterface

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller behind the MEM stage. It owns a 2^ADDR_W x 32 RAM
// that is shared by the integer and FP load/store paths. It serves the integer
// path first, models LAT cycles of latency per access, and holds mem_stall
// high until every accepted access has finished.
// Ports:
//   clk  - core clock
//   rst  - asynchronous, active-low reset (the RAM contents are kept)
//   bus  - dmem_ctrl_if.slave: requests from both paths, registered load
//          data with rvalid pulses, and the combinational mem_stall and the
//          misalign pulse
// LAT must be in the range 1..15 to fit the 4-bit latency counter.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC_I, ACC_F, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    // Control side of the latched request. These registers are reset.
    logic pend_i_en, pend_f_en;

    // Data side of the latched request. These registers are not reset. Only
    // the index bits and the alignment bits are kept.
    logic              pend_i_we, pend_f_we;
    logic [ADDR_W+1:0] pend_i_addr, pend_f_addr;
    logic [31:0]       pend_i_wdata, pend_f_wdata;

    logic [31:0] mem [2**ADDR_W];

    logic              accept, commit_i, commit_f, commit;
    logic              cur_we, cur_mis, mem_we;
    logic [ADDR_W+1:0] cur_addr;
    logic [ADDR_W-1:0] cur_idx;
    logic [31:0]       cur_wdata, rd_word;

    // The upper address bits alias onto the RAM on purpose, so they are
    // collected here and not used.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.req_i_addr[31:ADDR_W+2], bus.req_f_addr[31:ADDR_W+2]};

    // ---- next state and counter ----
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        commit_i = 1'b0;
        commit_f = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_i_en || bus.req_f_en) begin
                    accept   = 1'b1;
                    state_nx = bus.req_i_en ? ACC_I : ACC_F;
                    cnt_nx   = CNT_LOAD;
                end
            end
            ACC_I: begin
                if (cnt == 4'd0) begin
                    commit_i = 1'b1;
                    if (pend_f_en) begin
                        state_nx = ACC_F;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACC_F: begin
                if (cnt == 4'd0) begin
                    commit_f = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            // In DONE the request inputs still belong to the instruction that
            // just completed, so they are ignored.
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // At most one path commits per edge, so the RAM needs one shared port.
    assign commit    = commit_i | commit_f;
    assign cur_we    = commit_i ? pend_i_we    : pend_f_we;
    assign cur_addr  = commit_i ? pend_i_addr  : pend_f_addr;
    assign cur_wdata = commit_i ? pend_i_wdata : pend_f_wdata;
    assign cur_mis   = (cur_addr[1:0] != 2'b00);
    assign cur_idx   = cur_addr[ADDR_W+1:2];
    assign mem_we    = commit && cur_we && !cur_mis;
    assign rd_word   = mem[cur_idx];

    assign bus.mem_stall = (state == ACC_I) || (state == ACC_F) ||
                           ((state == IDLE) && (bus.req_i_en || bus.req_f_en));

    // ---- control registers and registered responses ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            pend_i_en    <= 1'b0;
            pend_f_en    <= 1'b0;
            bus.rdata_i  <= 32'd0;
            bus.rdata_f  <= 32'd0;
            bus.rvalid_i <= 1'b0;
            bus.rvalid_f <= 1'b0;
            bus.misalign <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bus.rvalid_i <= commit_i && !pend_i_we;
            bus.rvalid_f <= commit_f && !pend_f_we;
            bus.misalign <= commit && cur_mis;
            if (accept) begin
                pend_i_en <= bus.req_i_en;
                pend_f_en <= bus.req_f_en;
            end
            // A misaligned load returns zero and still pulses rvalid.
            if (commit_i && !pend_i_we)
                bus.rdata_i <= cur_mis ? 32'd0 : rd_word;
            if (commit_f && !pend_f_we)
                bus.rdata_f <= cur_mis ? 32'd0 : rd_word;
        end
    end

    // ---- request capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_i_we    <= bus.req_i_we;
            pend_i_addr  <= bus.req_i_addr[ADDR_W+1:0];
            pend_i_wdata <= bus.req_i_wdata;
            pend_f_we    <= bus.req_f_we;
            pend_f_addr  <= bus.req_f_addr[ADDR_W+1:0];
            pend_f_wdata <= bus.req_f_wdata;
        end
    end

    // ---- RAM write ----
    // While reset is asserted the state is IDLE, so a store that has not yet
    // reached its commit edge cannot write.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[cur_idx] <= cur_wdata;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst4;
    dmem_ctrl_if bus();
    dmem_ctrl_if bus4();

    dmem_ctrl #(.ADDR_W(10), .LAT(2)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    dmem_ctrl #(.ADDR_W(10), .LAT(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        i_en, i_we;
        logic [31:0] i_addr, i_wdata;
        logic        f_en, f_we;
        logic [31:0] f_addr, f_wdata;
        int          stall;
        logic [31:0] rd_i, rd_f;
        int          n_rvi, n_rvf, n_mis;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_i_en = 0; bus.req_i_we = 0; bus.req_i_addr = 0; bus.req_i_wdata = 0;
        bus.req_f_en = 0; bus.req_f_we = 0; bus.req_f_addr = 0; bus.req_f_wdata = 0;
    endtask

    task automatic idle_bus4();
        bus4.req_i_en = 0; bus4.req_i_we = 0; bus4.req_i_addr = 0; bus4.req_i_wdata = 0;
        bus4.req_f_en = 0; bus4.req_f_we = 0; bus4.req_f_addr = 0; bus4.req_f_wdata = 0;
    endtask

    // The caller has just driven a request and waited #1 after a negedge.
    // This samples once per cycle until mem_stall drops (the DONE cycle), and
    // counts the stall cycles and the pulses, including those seen in DONE.
    task automatic wait_done(output int stall_n, output int n_rvi, output int n_rvf,
                             output int n_mis, output int c_rvi, output int c_rvf,
                             output bit ok);
        stall_n = 0; n_rvi = 0; n_rvf = 0; n_mis = 0; c_rvi = -1; c_rvf = -1; ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.rvalid_i) begin n_rvi++; c_rvi = k; end
            if (bus.rvalid_f) begin n_rvf++; c_rvf = k; end
            if (bus.misalign) n_mis++;
            if (!bus.mem_stall) begin ok = 1; break; end
            stall_n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stall_n, n_rvi, n_rvf, n_mis, c_rvi, c_rvf;
        bit ok;
        @(negedge clk);
        bus.req_i_en = v.i_en; bus.req_i_we = v.i_we; bus.req_i_addr = v.i_addr; bus.req_i_wdata = v.i_wdata;
        bus.req_f_en = v.f_en; bus.req_f_we = v.f_we; bus.req_f_addr = v.f_addr; bus.req_f_wdata = v.f_wdata;
        #1;
        wait_done(stall_n, n_rvi, n_rvf, n_mis, c_rvi, c_rvf, ok);
        idle_bus();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL v%0d timeout: mem_stall still 1 after 40 cycles, expected it to drop", idx);
        end
        // One more IDLE cycle must carry no leftover pulse.
        @(negedge clk); #1;
        if (bus.rvalid_i) n_rvi++;
        if (bus.rvalid_f) n_rvf++;
        if (bus.misalign) n_mis++;
        check($sformatf("v%0d stall_cycles", idx), stall_n, v.stall);
        check($sformatf("v%0d rvalid_i_pulses", idx), n_rvi, v.n_rvi);
        check($sformatf("v%0d rvalid_f_pulses", idx), n_rvf, v.n_rvf);
        check($sformatf("v%0d misalign_pulses", idx), n_mis, v.n_mis);
        check($sformatf("v%0d rdata_i", idx), bus.rdata_i, v.rd_i);
        check($sformatf("v%0d rdata_f", idx), bus.rdata_f, v.rd_f);
        if (v.n_rvi == 1 && v.n_rvf == 1)
            check($sformatf("v%0d int_before_fp", idx), 32'(c_rvi < c_rvf), 32'd1);
    endtask

    // Integer-path transaction on the LAT=4 instance, bounded.
    task automatic txn4(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit ok = 0;
        @(negedge clk);
        bus4.req_i_en = 1; bus4.req_i_we = we; bus4.req_i_addr = addr; bus4.req_i_wdata = wdata;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (!bus4.mem_stall) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        idle_bus4();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lat4 timeout: mem_stall still 1 after 40 cycles, expected it to drop");
        end
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1);
    end

    initial begin
        int stall_n, n_rvi, n_rvf, n_mis, c_rvi, c_rvf;
        bit ok;

        vecs[0]  = '{1, 1, 32'h40,   32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        3, 32'h0,        32'h0,        0, 0, 0};
        vecs[1]  = '{1, 0, 32'h40,   32'h0,        0, 0, 32'h0,  32'h0,        3, 32'hDEADBEEF, 32'h0,        1, 0, 0};
        vecs[2]  = '{1, 1, 32'h80,   32'h11111111, 1, 0, 32'h80, 32'h0,        5, 32'hDEADBEEF, 32'h11111111, 0, 1, 0};
        vecs[3]  = '{0, 0, 32'h0,    32'h0,        1, 0, 32'h42, 32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 1, 1};
        vecs[4]  = '{1, 1, 32'h41,   32'h0BADF00D, 0, 0, 32'h0,  32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 0, 1};
        vecs[5]  = '{1, 0, 32'h40,   32'h0,        0, 0, 32'h0,  32'h0,        3, 32'hDEADBEEF, 32'h0,        1, 0, 0};
        vecs[6]  = '{1, 1, 32'h1000, 32'hA5A5A5A5, 0, 0, 32'h0,  32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 0, 0};
        vecs[7]  = '{1, 0, 32'h0,    32'h0,        0, 0, 32'h0,  32'h0,        3, 32'hA5A5A5A5, 32'h0,        1, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,    32'h0,        1, 1, 32'h84, 32'h55AA55AA, 3, 32'hA5A5A5A5, 32'h0,        0, 0, 0};
        vecs[9]  = '{1, 0, 32'h84,   32'h0,        1, 0, 32'h80, 32'h0,        5, 32'h55AA55AA, 32'h11111111, 1, 1, 0};
        vecs[10] = '{1, 0, 32'h40,   32'h0,        1, 0, 32'h81, 32'h0,        5, 32'hDEADBEEF, 32'h0,        1, 1, 1};

        idle_bus();
        idle_bus4();
        rst = 1; rst4 = 1;
        #2 rst = 0; rst4 = 0;
        @(negedge clk); #1;
        check("reset rdata_i", bus.rdata_i, 32'h0);
        check("reset rdata_f", bus.rdata_f, 32'h0);
        check("reset flags {rvi,rvf,mis,stall}", {28'h0, bus.rvalid_i, bus.rvalid_f, bus.misalign, bus.mem_stall}, 32'h0);
        @(negedge clk); rst = 1; rst4 = 1;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], i);

        // The load is held through DONE. Only one access may happen, and the
        // following IDLE cycle accepts a new request.
        @(negedge clk);
        bus.req_i_en = 1; bus.req_i_we = 0; bus.req_i_addr = 32'h0;
        #1;
        wait_done(stall_n, n_rvi, n_rvf, n_mis, c_rvi, c_rvf, ok);
        check("gate first done_reached", 32'(ok), 32'd1);
        check("gate first stall_cycles", stall_n, 3);
        check("gate first rvalid_i_pulses", n_rvi, 1);
        check("gate first rdata_i", bus.rdata_i, 32'hA5A5A5A5);
        @(negedge clk); #1;
        bus.req_i_addr = 32'h40;
        #1;
        check("gate idle rvalid_i", 32'(bus.rvalid_i), 32'd0);
        check("gate idle accepts", 32'(bus.mem_stall), 32'd1);
        wait_done(stall_n, n_rvi, n_rvf, n_mis, c_rvi, c_rvf, ok);
        idle_bus();
        check("gate second stall_cycles", stall_n, 3);
        check("gate second rvalid_i_pulses", n_rvi, 1);
        check("gate second rdata_i", bus.rdata_i, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("gate after rvalid_i", 32'(bus.rvalid_i), 32'd0);

        // Reset in the middle of an access, LAT=4. The store must be dropped.
        txn4(1'b1, 32'h20, 32'hCAFEF00D);
        txn4(1'b0, 32'h20, 32'h0);
        check("lat4 preload rdata_i", bus4.rdata_i, 32'hCAFEF00D);
        @(negedge clk);
        bus4.req_i_en = 1; bus4.req_i_we = 1; bus4.req_i_addr = 32'h20; bus4.req_i_wdata = 32'h12345678;
        #1;
        check("lat4 store accepted", 32'(bus4.mem_stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        idle_bus4();
        rst4 = 0;
        #1;
        check("lat4 midreset rdata_i", bus4.rdata_i, 32'h0);
        check("lat4 midreset rdata_f", bus4.rdata_f, 32'h0);
        check("lat4 midreset flags", {28'h0, bus4.rvalid_i, bus4.rvalid_f, bus4.misalign, bus4.mem_stall}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1;
        txn4(1'b0, 32'h20, 32'h0);
        check("lat4 store dropped", bus4.rdata_i, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the MEM stage.
- Owns the data RAM shared by the integer load/store path and the FP load/store path (FLW/FSW).
- Arbitrates between the two paths, models a fixed multi-cycle access latency and returns read data.
- Drives mem_stall, which freezes EX/MEM until every pending access has completed.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth = 2^ADDR_W 32-bit words.
- LAT, 2, access latency in cycles per request (legal range 1..15).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- req_i_en  in  1  integer-path access request; level, held while mem_stall=1.
- req_i_we  in  1  integer path: 1 = store, 0 = load.
- req_i_addr  in  32  integer-path byte address.
- req_i_wdata  in  32  integer-path store data.
- req_f_en  in  1  FP-path access request; level, held while mem_stall=1.
- req_f_we  in  1  FP path: 1 = FSW, 0 = FLW.
- req_f_addr  in  32  FP-path byte address.
- req_f_wdata  in  32  FP-path store data.
- rdata_i  out  32  integer load data; registered, held until the next integer load completes.
- rvalid_i  out  1  one-cycle pulse when rdata_i is updated.
- rdata_f  out  32  FP load data; registered, held until the next FP load completes.
- rvalid_f  out  1  one-cycle pulse when rdata_f is updated.
- mem_stall  out  1  combinational; high while any accepted request is unfinished.
- misalign  out  1  one-cycle pulse on completion of an access with addr[1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, pending flags cleared.
  - rdata_i, rdata_f, rvalid_i, rvalid_f and misalign all go to 0.
  - RAM contents are not reset and are retained.
  - Reset asserted mid-access aborts that access. A store whose commit edge has not yet occurred is dropped.
- States: IDLE, ACC_I, ACC_F, DONE.
- IDLE:
  - If req_i_en or req_f_en is high, latch both ports' en/we/addr/wdata at the clock edge into pend_i/pend_f.
  - Go to ACC_I if pend_i, else ACC_F.
  - Load the counter with LAT-1.
  - With no request, stay in IDLE.
- ACC_x:
  - Decrement the counter each cycle.
  - On the edge leaving a counter==0 cycle, the access commits:
    - A store writes RAM[addr[ADDR_W+1:2]].
    - A load registers the RAM word into rdata_x and pulses rvalid_x on the next cycle.
  - After ACC_I, go to ACC_F (counter reloaded to LAT-1) if pend_f is set, else go to DONE.
  - After ACC_F, go to DONE.
- DONE:
  - Lasts one cycle with mem_stall=0, which lets upstream advance.
  - Request inputs are ignored in this cycle because they still belong to the completed instruction.
  - Go to IDLE unconditionally.
- mem_stall:
  - Equals 1 in ACC_I and ACC_F.
  - Equals 1 in IDLE when req_i_en or req_f_en is high.
  - Equals 0 otherwise.
  - A single request therefore stalls for 1+LAT cycles; a dual request stalls for 1+2·LAT cycles.
- Priority and ordering:
  - When both paths request in the same cycle, the integer path is served first.
  - An FP load to the same word as a simultaneous integer store returns the new (stored) data.
- Address rules:
  - Only bits [ADDR_W+1:2] index the RAM; higher bits are ignored (aliasing wrap-around).
  - If addr[1:0] != 0, no RAM write occurs, a load returns 0 with rvalid, and misalign pulses together with that access's completion.
  - For a misaligned store, misalign pulses alone.
- Stores never pulse rvalid_x.
- A request that deasserts en while mem_stall=1 is a protocol violation. The latched copy is used regardless.

Test Plan:
- Reset then store-load, LAT=2: int store 0xDEADBEEF to 0x40, then int load from 0x40 → stall high for exactly 3 cycles each; rdata_i=0xDEADBEEF with a 1-cycle rvalid_i pulse; rvalid_i stays 0 for the store.
- Simultaneous requests: int store 0x11111111 to 0x80 and FP load from 0x80 in the same cycle → stall high for 5 cycles; rdata_f=0x11111111; the int access commits before the FP access.
- Misaligned access: FP load from 0x42 → misalign pulses, rdata_f=0, RAM unchanged. Int store to 0x41 → RAM[0x10] (byte address 0x40) unchanged.
- Address aliasing with ADDR_W=10: store 0xA5A5A5A5 to 0x1000, then load from 0x0000 → 0xA5A5A5A5.
- Reset mid-access: store 0x12345678 to 0x20 with LAT=4; assert rst after 2 ACC cycles; reload 0 then read 0x20 → old value returned (store dropped); all outputs 0 during reset.
- DONE gating: hold req_i_en high with the same load through DONE → exactly one access and one rvalid_i pulse; the next cycle's new request is accepted from IDLE.
